// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-requester arbiter for a single-port synchronous SRAM
//
// Purpose:
//   Shares one single-port synchronous SRAM between a reader (command fetch)
//   and a writer (time logger). Accesses are serialised, each issue is marked
//   by a one-cycle grant pulse, and read data comes back with a valid strobe.
//
// Build option:
//   SRAM_ARB_WR_PRIORITY_EN  defined   -> writer always wins a simultaneous request
//                            undefined -> round-robin on simultaneous requests
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-low reset
//   rd_req     in   read request level, held until rd_gnt
//   rd_addr    in   read address
//   rd_gnt     out  read issued to SRAM this cycle
//   rd_data    out  registered read data, held until the next read capture
//   rd_valid   out  rd_data valid this cycle
//   wr_req     in   write request level, held until wr_gnt
//   wr_addr    in   write address
//   wr_data    in   write data
//   wr_gnt     out  write issued to SRAM this cycle
//   mem_en     out  SRAM enable
//   mem_we     out  SRAM write enable
//   mem_addr   out  SRAM address
//   mem_wdata  out  SRAM write data
//   mem_rdata  in   SRAM read data, valid the cycle after an enabled read
//   busy       out  arbiter is not idle

module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_SIZE  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic [DATA_SIZE-1:0]  rd_data,
    output logic                  rd_valid,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0]  wr_data,
    output logic                  wr_gnt,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_SIZE-1:0]  mem_wdata,
    input  logic [DATA_SIZE-1:0]  mem_rdata,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_RD_DONE  = 3'd3,
        S_WR_ISSUE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_wr_q, last_wr_d;   // 1: most recent grant went to the writer
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_SIZE-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DATA_SIZE-1:0]    rd_data_q, rd_data_d;

    // Arbitration decision, evaluated every cycle but only acted on in the
    // cycles that are allowed to start a new access.
    logic                    pick_rd;
    logic                    pick_wr;

    always_comb begin
`ifdef SRAM_ARB_WR_PRIORITY_EN
        pick_rd = rd_req && !wr_req;
`else
        pick_rd = rd_req && (!wr_req || last_wr_q);
`endif
        pick_wr = wr_req && !pick_rd;
    end

    always_comb begin
        state_d     = state_q;
        last_wr_d   = last_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        rd_gnt      = 1'b0;
        wr_gnt      = 1'b0;
        rd_valid    = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        busy        = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (pick_rd) begin
                    state_d    = S_RD_ISSUE;
                    mem_addr_d = rd_addr;
                end else if (pick_wr) begin
                    state_d     = S_WR_ISSUE;
                    mem_addr_d  = wr_addr;
                    mem_wdata_d = wr_data;
                end
            end

            S_RD_ISSUE: begin
                mem_en    = 1'b1;
                rd_gnt    = 1'b1;
                last_wr_d = 1'b0;
                state_d   = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                rd_data_d = mem_rdata;
                state_d   = S_RD_DONE;
            end

            // The data-return cycle doubles as an arbitration cycle so that
            // back-to-back reads run at one per three cycles instead of four.
            S_RD_DONE: begin
                rd_valid = 1'b1;
                state_d  = S_IDLE;
                if (pick_rd) begin
                    state_d    = S_RD_ISSUE;
                    mem_addr_d = rd_addr;
                end else if (pick_wr) begin
                    state_d     = S_WR_ISSUE;
                    mem_addr_d  = wr_addr;
                    mem_wdata_d = wr_data;
                end
            end

            S_WR_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                wr_gnt    = 1'b1;
                last_wr_d = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            last_wr_q   <= 1'b1;    // first contended access goes to the reader
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_wr_q   <= last_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_data   = rd_data_q;

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

- Arbitrates one single-port synchronous SRAM between two requesters in the watch design:
  - the command reader, which fetches 32-bit command words;
  - the time logger, which stores the current time words.
- Sits between those requesters and the SRAM macro and owns all SRAM control signals.
- Serialises accesses, grants with a one-cycle pulse and returns read data with a valid strobe.
- Uses round-robin arbitration on simultaneous requests by default.

## Interface

Parameters:
- ADDR_WIDTH, 10, SRAM address width (1024 locations)
- DATA_SIZE, 32, SRAM word width

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-low reset
- rd_req  in  1  read request; level, held until rd_gnt
- rd_addr  in  ADDR_WIDTH  read address; stable while rd_req high
- rd_gnt  out  1  one-cycle pulse; read issued to SRAM this cycle
- rd_data  out  DATA_SIZE  registered read data
- rd_valid  out  1  one-cycle pulse; rd_data valid this cycle
- wr_req  in  1  write request; level, held until wr_gnt
- wr_addr  in  ADDR_WIDTH  write address; stable while wr_req high
- wr_data  in  DATA_SIZE  write data; stable while wr_req high
- wr_gnt  out  1  one-cycle pulse; write issued to SRAM this cycle
- mem_en  out  1  SRAM enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_WIDTH  SRAM address
- mem_wdata  out  DATA_SIZE  SRAM write data
- mem_rdata  in  DATA_SIZE  SRAM read data; valid one cycle after an enabled read
- busy  out  1  high in any state other than IDLE

## Operation

- Reset (rst=0 at a clk edge):
  - state goes to IDLE;
  - all outputs go to 0, including rd_data;
  - last_grant is set to WRITE, so the first contended access goes to the reader.
- States: IDLE, RD_ISSUE, RD_WAIT, RD_DONE, WR_ISSUE.
- IDLE: samples rd_req and wr_req, then:
  - neither asserted: stay in IDLE;
  - only one asserted: go to that requester's ISSUE state;
  - both asserted: grant the requester that is not last_grant.
- On the IDLE transition, the winner's address and data are captured into the mem_* registers.
- RD_ISSUE:
  - mem_en=1, mem_we=0, rd_gnt=1;
  - last_grant<=READ;
  - next state RD_WAIT.
- RD_WAIT: mem_rdata is captured into rd_data; next state RD_DONE.
- RD_DONE: rd_valid=1; next state IDLE.
- WR_ISSUE:
  - mem_en=1, mem_we=1, wr_gnt=1;
  - mem_wdata=captured wr_data;
  - last_grant<=WRITE;
  - next state IDLE.
- Outside the ISSUE states, mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
- Requesters must deassert req in the cycle after their gnt.
  - A req still high in IDLE is treated as a new request.
- No address range checking: addresses are used as given, modulo 2^ADDR_WIDTH.
- A request arriving while busy waits in its req line. The arbiter keeps no queue.

## Timing

- Cycle numbering: T is the IDLE cycle in which a request is sampled.
- Read:
  - rd_gnt and mem_en at T+1;
  - mem_rdata valid at T+2;
  - rd_valid and rd_data at T+3;
  - next arbitration at T+3, next access at T+4.
- Write:
  - wr_gnt, mem_en and mem_we at T+1;
  - next arbitration at T+2.
- Throughput: one read per 3 cycles, or one write per 2 cycles.
- Alternating contention on a read/write pair takes 5 cycles.
- rd_data holds its value until the next RD_WAIT or reset.
- Reset mid-operation:
  - the access in flight is abandoned;
  - no gnt and no rd_valid are produced for it;
  - the requester must re-request after reset.
- At most one of rd_gnt and wr_gnt is high in any cycle.
- rd_valid is never high in the same cycle as a gnt.

## Configuration

- Macro: SRAM_ARB_WR_PRIORITY_EN.
- Defined: fixed priority. When both requests are asserted in IDLE, the writer always wins and last_grant is ignored.
  - The reader can be starved by continuous writes. This is accepted because the logger writes once per second.
- Undefined: round-robin, as described under Operation.
- Single-requester behaviour and timing are identical in both builds.

## Test plan

- Single read:
  - preload address 5 with 0xDEADBEEF;
  - rd_req=1, rd_addr=5 sampled at T;
  - expect rd_gnt and mem_en at T+1, then rd_valid at T+3 with rd_data=0xDEADBEEF.
- Single write, then read-back:
  - wr_req with wr_addr=10 and wr_data=0x00000959;
  - expect wr_gnt, mem_en=1 and mem_we=1 at T+1, with mem_addr=10;
  - a following read of address 10 returns 0x00000959.
- Contention:
  - both requests held continuously after reset;
  - round-robin build: grant order R, W, R, W, with a gnt every 5 cycles per pair;
  - SRAM_ARB_WR_PRIORITY_EN build: W repeats and the reader is never granted.
- Reset in RD_WAIT:
  - assert rst=0 for one cycle;
  - expect rd_valid never pulses, all outputs are 0, busy=0, and rd_data=0.
- Back-to-back reads to addresses 0, 1 and 2 with the requester dropping req after each gnt:
  - expect three rd_valid pulses spaced 3 cycles apart, with data in address order;
  - expect no duplicate grants.
